stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter SIZE, default 4: width of stage durations and of the remaining-seconds count.
REQ-002 Parameter NSTAGE, default 4: number of programmable stages; stage index width is clog2(NSTAGE).
REQ-003 Parameter TICKS, default 1000: clk cycles per second (clk nominally 1 kHz).
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_we  in  1  write strobe for the stage table.
REQ-007 cfg_idx  in  clog2(NSTAGE)  stage table write index.
REQ-008 cfg_max  in  SIZE  duration in seconds for stage cfg_idx.
REQ-009 start  in  1  begin sequence (sampled in IDLE only).
REQ-010 pause  in  1  level; freezes counting while high in RUN.
REQ-011 abort  in  1  return to IDLE from any state.
REQ-012 alarm_ack  in  1  clears the alarm.
REQ-013 busy  out  1  high in LOAD, RUN and PAUSED.
REQ-014 stage  out  clog2(NSTAGE)  current stage index.
REQ-015 remaining  out  SIZE  seconds left in the current stage.
REQ-016 sec_tick  out  1  one-cycle pulse per elapsed counted second.
REQ-017 stage_done  out  1  one-cycle pulse when a stage reaches zero.
REQ-018 alarm  out  1  level; high in ALARM.

Function
REQ-019 States SHALL be IDLE, LOAD, RUN, PAUSED and ALARM.
REQ-020 Stage table: NSTAGE registers of SIZE bits; cfg_we writes cfg_max to entry cfg_idx only in IDLE or ALARM; writes SHALL be ignored while busy.
REQ-021 IDLE: start=1 -> LOAD next cycle, stage=0.
REQ-022 LOAD (one cycle): table[stage]!=0 -> remaining=table[stage], prescaler=0, RUN; table[stage]==0 -> stage skipped without a stage_done pulse, stage+1 and stay in LOAD, or ALARM if stage is last.
REQ-023 RUN: prescaler counts 0..TICKS-1; at TICKS-1 it wraps to 0, sec_tick pulses and remaining decrements in the same cycle.
REQ-024 When remaining goes 1->0, stage_done SHALL pulse in that same cycle; next state is LOAD with stage+1, or ALARM if stage==NSTAGE-1.
REQ-025 A stage of duration N SHALL occupy exactly N*TICKS cycles in RUN, excluding paused cycles.
REQ-026 RUN with pause=1 -> PAUSED; prescaler and remaining hold; no sec_tick. PAUSED with pause=0 -> RUN, resuming from the held prescaler value.
REQ-027 pause SHALL be ignored in IDLE, LOAD and ALARM.
REQ-028 ALARM: alarm=1, stage holds the last index and remaining=0; alarm_ack=1 -> IDLE next cycle.
REQ-029 Priority per cycle: abort > pause > second tick; abort in any state -> IDLE next cycle, with no sec_tick or stage_done pulse in that cycle.
REQ-030 start SHALL be ignored outside IDLE; start and abort together in IDLE leave the block in IDLE.
REQ-031 Arithmetic SHALL be unsigned; remaining never wraps below 0.

Reset
REQ-032 On rst: state=IDLE; stage=0, remaining=0, prescaler=0; busy, sec_tick, stage_done and alarm = 0.
REQ-033 rst asserted mid-sequence SHALL take effect immediately (asynchronously) and abandon the sequence.
REQ-034 Stage table entries SHALL reset to 0.

Verification (TICKS=4, SIZE=4, NSTAGE=4)
REQ-035 Table {2,1,0,3}, start pulse -> stage_done at RUN cycles 8, 12 and 24; stage 2 is skipped; alarm=1 one cycle after the final stage_done; 6 sec_tick pulses in total.
REQ-036 Table {3,0,0,0}, pause high for 5 cycles after the 2nd sec_tick -> remaining holds at 1 during the pause; stage_done occurs exactly 5 cycles later than without the pause.
REQ-037 abort during stage 1 with remaining=1 -> next cycle busy=0, alarm=0, no stage_done; a following start begins again at stage 0.
REQ-038 cfg_we with cfg_idx=0 and cfg_max=7 while busy -> entry 0 unchanged; the next run of stage 0 still loads the old value.
REQ-039 All entries 0, start -> ALARM reached with no sec_tick; alarm_ack -> IDLE next cycle.
REQ-040 rst pulse while in ALARM -> all outputs 0 immediately; table reads back as zero, proven by start going straight to ALARM.

Source files
------------

// File: rtl/stage_sequencer.sv
// Programmable multi-stage countdown sequencer: walks a table of per-stage
// durations in seconds, pulsing sec_tick and stage_done, and ends in ALARM.
module stage_sequencer #(
    parameter int SIZE   = 4,
    parameter int NSTAGE = 4,
    parameter int TICKS  = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(NSTAGE)-1:0] cfg_idx,
    input  logic [SIZE-1:0]           cfg_max,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      abort,
    input  logic                      alarm_ack,
    output logic                      busy,
    output logic [$clog2(NSTAGE)-1:0] stage,
    output logic [SIZE-1:0]           remaining,
    output logic                      sec_tick,
    output logic                      stage_done,
    output logic                      alarm
);

    localparam int IW = $clog2(NSTAGE);
    localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        ALARM  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   stage_q, stage_d;
    logic [SIZE-1:0] remaining_q, remaining_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            busy_q, busy_d;
    logic            sec_tick_q, sec_tick_d;
    logic            stage_done_q, stage_done_d;
    logic            alarm_q, alarm_d;

    logic [SIZE-1:0] table_q [NSTAGE];
    logic [SIZE-1:0] table_d [NSTAGE];
    logic [NSTAGE-1:0] wr_en;
    logic            cfg_ok;
    logic            last_stage;
    logic [SIZE-1:0] cur_max;

    // The table may only be reprogrammed while no sequence is in flight.
    assign cfg_ok = cfg_we && ((state_q == IDLE) || (state_q == ALARM));

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_wr
            assign wr_en[gi] = cfg_ok && (cfg_idx == IW'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NSTAGE; i++) begin
            table_d[i] = wr_en[i] ? cfg_max : table_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTAGE; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSTAGE; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign last_stage = (stage_q == IW'(NSTAGE - 1));
    assign cur_max    = table_q[stage_q];

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        remaining_d  = remaining_q;
        presc_d      = presc_q;
        sec_tick_d   = 1'b0;
        stage_done_d = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            stage_d     = '0;
            remaining_d = '0;
            presc_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = LOAD;
                        stage_d     = '0;
                        remaining_d = '0;
                        presc_d     = '0;
                    end
                end
                LOAD: begin
                    presc_d = '0;
                    if (cur_max != '0) begin
                        remaining_d = cur_max;
                        state_d     = RUN;
                    end else if (last_stage) begin
                        remaining_d = '0;
                        state_d     = ALARM;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end
                RUN, PAUSED: begin
                    // A paused cycle with pause released counts like a RUN cycle,
                    // so a pause of P high cycles delays the stage by exactly P.
                    if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        state_d = RUN;
                        if (presc_q == PW'(TICKS - 1)) begin
                            presc_d    = '0;
                            sec_tick_d = 1'b1;
                            if (remaining_q != '0) begin
                                remaining_d = remaining_q - 1'b1;
                            end
                            if (remaining_q <= SIZE'(1)) begin
                                stage_done_d = 1'b1;
                                if (last_stage) begin
                                    state_d = ALARM;
                                end else begin
                                    state_d = LOAD;
                                    stage_d = stage_q + 1'b1;
                                end
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                ALARM: begin
                    remaining_d = '0;
                    if (alarm_ack) begin
                        state_d = IDLE;
                        stage_d = '0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    stage_d     = '0;
                    remaining_d = '0;
                    presc_d     = '0;
                end
            endcase
        end

        busy_d  = (state_d == LOAD) || (state_d == RUN) || (state_d == PAUSED);
        // alarm rises one cycle after entering ALARM, so it never overlaps the
        // final stage_done pulse, and drops on the same edge that leaves ALARM.
        alarm_d = (state_q == ALARM) && !alarm_ack && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            remaining_q  <= '0;
            presc_q      <= '0;
            busy_q       <= 1'b0;
            sec_tick_q   <= 1'b0;
            stage_done_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            remaining_q  <= remaining_d;
            presc_q      <= presc_d;
            busy_q       <= busy_d;
            sec_tick_q   <= sec_tick_d;
            stage_done_q <= stage_done_d;
            alarm_q      <= alarm_d;
        end
    end

    assign busy       = busy_q;
    assign stage      = stage_q;
    assign remaining  = remaining_q;
    assign sec_tick   = sec_tick_q;
    assign stage_done = stage_done_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with TICKS=4; cycle numbers count
// sampled clock edges after start is driven (edge 1 samples start).
module tb_stage_sequencer;

    localparam int SIZE   = 4;
    localparam int NSTAGE = 4;
    localparam int TICKS  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [3:0] cfg_max;
    logic       start;
    logic       pause;
    logic       abort;
    logic       alarm_ack;
    logic       busy;
    logic [1:0] stage;
    logic [3:0] remaining;
    logic       sec_tick;
    logic       stage_done;
    logic       alarm;

    int n_checks = 0;
    int n_fail   = 0;
    int done_at[$];
    int n_ticks;
    int first_alarm;
    int stage_log [64];
    int rem_log   [64];

    always #5 clk = ~clk;

    stage_sequencer #(
        .SIZE  (SIZE),
        .NSTAGE(NSTAGE),
        .TICKS (TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_max   (cfg_max),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .alarm_ack (alarm_ack),
        .busy      (busy),
        .stage     (stage),
        .remaining (remaining),
        .sec_tick  (sec_tick),
        .stage_done(stage_done),
        .alarm     (alarm)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int idx, input int val);
        cfg_we  = 1'b1;
        cfg_idx = idx[1:0];
        cfg_max = val[3:0];
        step();
        cfg_we  = 1'b0;
    endtask

    function automatic int done_or(input int k);
        return (done_at.size() > k) ? done_at[k] : -1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_stage"}, stage, 0);
        check_eq({tag, "_rem"}, remaining, 0);
        check_eq({tag, "_tick"}, sec_tick, 0);
        check_eq({tag, "_done"}, stage_done, 0);
        check_eq({tag, "_alarm"}, alarm, 0);
    endtask

    // Pulse start, then run n sampled cycles logging pulses; optionally hold
    // pause high for the 5 edges following the 2nd sec_tick.
    task automatic run_seq(input int n, input bit do_pause);
        int pstart;
        pstart      = -100;
        n_ticks     = 0;
        first_alarm = -1;
        done_at.delete();
        start = 1'b1;
        for (int i = 1; i <= n; i++) begin
            step();
            if (i == 1) start = 1'b0;
            stage_log[i] = int'(stage);
            rem_log[i]   = int'(remaining);
            if (stage_done) done_at.push_back(i);
            if (alarm && first_alarm < 0) first_alarm = i;
            if (i > pstart && i <= pstart + 5) check_eq("pause_hold_rem", remaining, 1);
            if (sec_tick) begin
                n_ticks++;
                if (do_pause && n_ticks == 2) begin
                    pause  = 1'b1;
                    pstart = i;
                end
            end
            if (i == pstart + 5) pause = 1'b0;
        end
        pause = 1'b0;
    endtask

    task automatic ack_alarm(input string tag);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check_eq({tag, "_ack_alarm"}, alarm, 0);
        check_eq({tag, "_ack_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_max = '0;
        start = 1'b0; pause = 1'b0; abort = 1'b0; alarm_ack = 1'b0;
        step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // Table is zero out of reset: LOAD skips all four stages into ALARM.
        run_seq(8, 1'b0);
        check_eq("zero_first_alarm", first_alarm, 6);
        check_eq("zero_ticks", n_ticks, 0);
        check_eq("zero_done_cnt", done_at.size(), 0);
        check_eq("zero_alarm_stage", stage_log[6], 3);
        ack_alarm("zero");

        // start together with abort in IDLE stays in IDLE.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", busy, 0);
        step();
        check_eq("start_abort_busy2", busy, 0);

        // Table {2,1,0,3}: done at 10,15,29 (RUN cycles 8,12,24), alarm at 30.
        write_entry(0, 2); write_entry(1, 1); write_entry(2, 0); write_entry(3, 3);
        run_seq(34, 1'b0);
        check_eq("seq_rem_load0", rem_log[2], 2);
        check_eq("seq_done_cnt", done_at.size(), 3);
        check_eq("seq_done0", done_or(0), 10);
        check_eq("seq_done1", done_or(1), 15);
        check_eq("seq_done2", done_or(2), 29);
        check_eq("seq_skip_stage2", stage_log[15], 2);
        check_eq("seq_skip_to3", stage_log[16], 3);
        check_eq("seq_rem_load3", rem_log[17], 3);
        check_eq("seq_ticks", n_ticks, 6);
        check_eq("seq_first_alarm", first_alarm, 30);
        check_eq("seq_alarm_stage", stage_log[31], 3);
        check_eq("seq_alarm_rem", rem_log[31], 0);
        ack_alarm("seq");

        // Write while busy is ignored; abort on the tick edge of stage 1 wins.
        run_seq(12, 1'b0);
        write_entry(0, 7);
        step();
        check_eq("abort_pre_stage", stage, 1);
        check_eq("abort_pre_rem", remaining, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_alarm", alarm, 0);
        check_eq("abort_done", stage_done, 0);
        check_eq("abort_tick", sec_tick, 0);
        step();
        check_eq("abort_busy2", busy, 0);
        check_eq("abort_done2", stage_done, 0);
        run_seq(2, 1'b0);
        check_eq("restart_stage", stage_log[1], 0);
        check_eq("restart_rem_old", rem_log[2], 2);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Table {3,0,0,0} with a 5-edge pause: done moves from 14 to 19.
        write_entry(0, 3); write_entry(1, 0); write_entry(3, 0);
        run_seq(26, 1'b1);
        check_eq("pause_done_cnt", done_at.size(), 1);
        check_eq("pause_done0", done_or(0), 19);
        check_eq("pause_ticks", n_ticks, 3);
        check_eq("pause_first_alarm", first_alarm, 23);
        ack_alarm("pause");

        // Asynchronous reset while in ALARM clears outputs and the table.
        write_entry(0, 1);
        run_seq(12, 1'b0);
        check_eq("rst_pre_alarm", first_alarm, 10);
        check_eq("rst_pre_alarm_lvl", alarm, 1);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        #1;
        rst = 1'b0;
        run_seq(8, 1'b0);
        check_eq("rst_tbl_first_alarm", first_alarm, 6);
        check_eq("rst_tbl_ticks", n_ticks, 0);
        ack_alarm("rst_tbl");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
